// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings,
// default geometry and the signed-overflow rule used when flags are registered.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_STEP  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    // Subtraction overflows only when the operand signs differ and the
    // result sign departs from the minuend sign.
    function automatic logic subOverflow(input logic aMsb, input logic bMsb, input logic resMsb);
        return (aMsb ^ bMsb) & (resMsb ^ aMsb);
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// STEP-bit ripple of full adders; the subtrahend arrives already inverted,
// so a carry-in of 1 on the first slice completes the two's-complement negate.
module serial_subtractor_sub_slice #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b_inv,
    input  logic            cin,
    output logic [STEP-1:0] sum,
    output logic            cout
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < STEP; i++) begin
            sum[i] = a[i] ^ b_inv[i] ^ carry;
            carry  = (a[i] & b_inv[i]) | (carry & (a[i] ^ b_inv[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle A - B: processes STEP bits per cycle LSB first, then holds
// result and carryout/overflow/zero behind a valid/ready output handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICES = WIDTH / STEP;
    localparam int CNT_W  = $clog2(SLICES) + 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(SLICES - 1);

    stateT state;
    stateT stateNext;

    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bInvReg;
    logic [WIDTH-1:0] sumShift;
    logic [WIDTH-1:0] sumShiftNext;
    logic             carryReg;
    logic [CNT_W-1:0] sliceCnt;
    logic             aMsb;
    logic             bMsb;

    logic [STEP-1:0]  sliceSum;
    logic             sliceCout;
    logic             accept;
    logic             lastSlice;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Handshake outputs are pure state decodes; no input feeds them combinationally.
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        lastSlice = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (sliceCnt == TERM_CNT) begin
                    lastSlice = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    serial_subtractor_sub_slice #(
        .STEP (STEP)
    ) uSubSlice (
        .a     (aReg[STEP-1:0]),
        .b_inv (bInvReg[STEP-1:0]),
        .cin   (carryReg),
        .sum   (sliceSum),
        .cout  (sliceCout)
    );

    // New sum bits enter at the MSB end; after SLICES shifts the first slice sits at bit 0.
    assign sumShiftNext = WIDTH'({sliceSum, sumShift} >> STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aReg     <= '0;
            bInvReg  <= '0;
            sumShift <= '0;
            carryReg <= 1'b0;
            sliceCnt <= '0;
            aMsb     <= 1'b0;
            bMsb     <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            aReg     <= operandA;
            bInvReg  <= ~operandB;
            sumShift <= '0;
            carryReg <= 1'b1;
            sliceCnt <= '0;
            aMsb     <= operandA[WIDTH-1];
            bMsb     <= operandB[WIDTH-1];
        end else if (state == RUN) begin
            aReg     <= aReg >> STEP;
            bInvReg  <= bInvReg >> STEP;
            sumShift <= sumShiftNext;
            carryReg <= sliceCout;
            sliceCnt <= sliceCnt + CNT_W'(1);
            if (lastSlice) begin
                result   <= sumShiftNext;
                carryout <= sliceCout;
                overflow <= subOverflow(aMsb, bMsb, sumShiftNext[WIDTH-1]);
                zero     <= ~|sumShiftNext;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed check of serial_subtractor at STEP=1 and STEP=4
// against a plain-arithmetic reference, with a queue-based scoreboard.
module tb_serial_subtractor;

    typedef struct {
        int          dut;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        int          acc;
    } expT;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid  [2];
    logic        inReady  [2];
    logic        outValid [2];
    logic        outReady [2];
    logic        carry    [2];
    logic        ovf      [2];
    logic        zro      [2];
    logic [31:0] opA      [2];
    logic [31:0] opB      [2];
    logic [31:0] res      [2];

    expT         sbq[$];
    int          nChecks = 0;
    int          nFail   = 0;
    int          cyc     = 0;
    int          lastAccept [2];
    logic        prevValid  [2];
    logic [31:0] lastRes    [2];
    logic        lastC      [2];
    logic        lastV      [2];
    logic        lastZ      [2];
    bit          randStall = 1'b0;

    logic [31:0] dirA [5] = '{32'd5, 32'd3, 32'h80000000, 32'h7FFFFFFF, 32'h00001234};
    logic [31:0] dirB [5] = '{32'd3, 32'd5, 32'h00000001, 32'hFFFFFFFF, 32'h00001234};

    serial_subtractor #(.WIDTH(32), .STEP(1)) dutS1 (
        .clk(clk), .reset(reset),
        .in_valid(inValid[0]), .in_ready(inReady[0]),
        .operandA(opA[0]), .operandB(opB[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .result(res[0]), .carryout(carry[0]), .overflow(ovf[0]), .zero(zro[0])
    );

    serial_subtractor #(.WIDTH(32), .STEP(4)) dutS4 (
        .clk(clk), .reset(reset),
        .in_valid(inValid[1]), .in_ready(inReady[1]),
        .operandA(opA[1]), .operandB(opB[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .result(res[1]), .carryout(carry[1]), .overflow(ovf[1]), .zero(zro[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (randStall) outReady[0] = 1'($urandom_range(0, 1));
    end

    function automatic int latOf(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic expT model(input int d, input logic [31:0] a, input logic [31:0] b);
        expT    e;
        longint sd;
        e.dut = d;
        e.res = a - b;
        e.c   = (a >= b);
        sd    = longint'($signed(a)) - longint'($signed(b));
        e.v   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        e.z   = (a == b);
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [31:0] randOperand();
        logic [31:0] specials [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s (dut%0d): actual 0x%08h, required 0x%08h", name, d, act, exp);
        end
    endtask

    task automatic monitorDut(input int d);
        expT e;
        if (reset) begin
            chk(d, "reset_out_valid", outValid[d], 0);
            chk(d, "reset_result", res[d], 0);
            chk(d, "reset_flags", {carry[d], ovf[d], zro[d]}, 0);
            if (d == 0) sbq.delete();
            prevValid[d] = 1'b0;
            lastRes[d]   = '0;
            lastC[d]     = 1'b0;
            lastV[d]     = 1'b0;
            lastZ[d]     = 1'b0;
            return;
        end
        if (outValid[d]) begin
            if (sbq.size() == 0 || sbq[0].dut != d) begin
                chk(d, "unexpected_output", outValid[d], 0);
            end else begin
                e = sbq[0];
                if (!prevValid[d]) chk(d, "latency", cyc - e.acc, latOf(d));
                chk(d, "result", res[d], e.res);
                chk(d, "carryout", carry[d], e.c);
                chk(d, "overflow", ovf[d], e.v);
                chk(d, "zero", zro[d], e.z);
                if (outReady[d]) begin
                    void'(sbq.pop_front());
                    lastRes[d] = e.res;
                    lastC[d]   = e.c;
                    lastV[d]   = e.v;
                    lastZ[d]   = e.z;
                end
            end
        end else begin
            chk(d, "hold_result", res[d], lastRes[d]);
            chk(d, "hold_flags", {carry[d], ovf[d], zro[d]}, {lastC[d], lastV[d], lastZ[d]});
        end
        prevValid[d] = outValid[d];
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitorDut(d);
    end

    // Presents operands and returns at the negedge just before the accepting edge.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input bit checkInterval);
        int  budget = 0;
        expT e;
        @(posedge clk);
        #1;
        inValid[d] = 1'b1;
        opA[d]     = a;
        opB[d]     = b;
        while (1) begin
            @(negedge clk);
            if (inReady[d]) break;
            budget++;
            if (budget > 300) begin
                chk(d, "accept_timeout", inReady[d], 1);
                inValid[d] = 1'b0;
                return;
            end
        end
        e     = model(d, a, b);
        e.acc = cyc + 1;
        sbq.push_back(e);
        if (checkInterval) chk(d, "throughput_interval", e.acc - lastAccept[d], latOf(d) + 2);
        lastAccept[d] = e.acc;
    endtask

    task automatic idle(input int d);
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (sbq.size() != 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        chk(0, "drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        int bp;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            inValid[d]    = 1'b0;
            opA[d]        = '0;
            opB[d]        = '0;
            outReady[d]   = 1'b1;
            lastAccept[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk(0, "in_ready_after_reset", inReady[0], 1);
        chk(1, "in_ready_after_reset", inReady[1], 1);

        for (int i = 0; i < 5; i++) begin
            send(0, dirA[i], dirB[i], 1'b0);
            idle(0);
            waitDrain();
        end

        // Back-to-back with in_valid held high: also proves DONE never accepts.
        for (int i = 0; i < 6; i++) send(0, randOperand(), randOperand(), i > 0);
        idle(0);
        waitDrain();

        randStall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            a = randOperand();
            send(0, a, ($urandom_range(0, 4) == 0) ? a : randOperand(), 1'b0);
            idle(0);
        end
        waitDrain();
        randStall = 1'b0;
        @(posedge clk);
        #1 outReady[0] = 1'b1;

        @(posedge clk);
        #1 outReady[0] = 1'b0;
        send(0, 32'hDEADBEEF, 32'h12345678, 1'b0);
        idle(0);
        bp = 0;
        while (!outValid[0] && bp < 100) begin
            @(negedge clk);
            bp++;
        end
        chk(0, "bp_reached_done", outValid[0], 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            inValid[0] = (i >= 3 && i <= 6);
            opA[0]     = $urandom;
            opB[0]     = $urandom;
            @(negedge clk);
            chk(0, "bp_in_ready", inReady[0], 0);
        end
        @(posedge clk);
        #1;
        inValid[0]  = 1'b0;
        outReady[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk(0, "bp_no_extra_accept", inReady[0], 1);
        chk(0, "bp_queue_empty", sbq.size(), 0);
        send(0, 32'h00000100, 32'h00000001, 1'b0);
        idle(0);
        waitDrain();

        send(0, 32'h0F0F0F0F, 32'h01010101, 1'b0);
        idle(0);
        repeat (16) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk(0, "midrun_reset_out_valid", outValid[0], 0);
        chk(0, "midrun_reset_result", res[0], 0);
        chk(0, "midrun_reset_flags", {carry[0], ovf[0], zro[0]}, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        chk(0, "in_ready_after_midrun_reset", inReady[0], 1);
        repeat (40) @(negedge clk);
        chk(0, "abandoned_never_presented", outValid[0], 0);
        send(0, 32'd5, 32'd3, 1'b0);
        idle(0);
        waitDrain();

        send(1, 32'd10, 32'd7, 1'b0);
        idle(1);
        waitDrain();
        for (int i = 0; i < 8; i++) send(1, randOperand(), randOperand(), i > 0);
        idle(1);
        waitDrain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
